// File: rtl/dram_arbiter.sv
// ----------------------------------------------------------------------------
// dram_arbiter
//   Shares one synchronous single-port byte-lane data RAM between two
//   requesters: port 0 (MEM-stage load/store) and port 1 (uncached/debug).
//   Does big-endian lane selection, store-data replication, load extraction
//   with sign/zero extension, and rejects misaligned accesses with an error
//   and no RAM cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   reqN/weN/addrN/     request, 1=store, byte address, right-aligned store
//   wdataN/typeN        data, type ([1:0] 00 byte/01 half/10 word/11 rsvd,
//                       [2] sign-extend loads)
//   ackN/errN/rdataN    one-cycle completion, address error, load result
//   busy                high whenever the FSM is not idle (stall hint)
//   ram_en/ram_be/      RAM cycle enable, byte write enables (bit3 = 31:24),
//   ram_addr/ram_wdata  word index, write data
//   ram_rdata           RAM read data, valid the cycle after ram_en
//   dbg_state           current FSM state (0 idle, 1 issue, 2 done)
//
// Handshake: a requester raises reqN with its command and holds both stable
// until it sees ackN high; it drops reqN on the clock edge where ackN is seen.
// ackN is a single-cycle pulse; errN and rdataN are meaningful only with it.
// ----------------------------------------------------------------------------
module dram_arbiter #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [31:0]       addr0,
   input  logic [31:0]       addr1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   input  logic [2:0]        type0,
   input  logic [2:0]        type1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [31:0]       rdata0,
   output logic [31:0]       rdata1,
   output logic              busy,
   output logic              ram_en,
   output logic [3:0]        ram_be,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                port_q, port_d;
   logic                we_q, we_d;
   logic [2:0]          type_q, type_d;
   logic [1:0]          lane_q, lane_d;
   logic                mis_q, mis_d;
   logic                ram_en_q, ram_en_d;
   logic [3:0]          ram_be_q, ram_be_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [31:0]         ram_wdata_q, ram_wdata_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic                err0_q, err0_d;
   logic                err1_q, err1_d;

   // Upper address bits lie outside the RAM and are ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr0[31:ADDR_W+2], addr1[31:ADDR_W+2]};

   // ------------------------------------------------------------------------
   // Grant selection and decode of the selected command
   // ------------------------------------------------------------------------
   logic        gnt_valid;
   logic        gnt_port;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [2:0]  sel_type;
   logic        sel_mis;
   logic [3:0]  sel_be;
   logic [31:0] sel_rep;

   always_comb begin
      gnt_valid = req0 | req1;
      // On contention the port that was not served last wins.
      gnt_port  = (req0 & req1) ? ~last_grant_q : req1;
      sel_we    = gnt_port ? we1    : we0;
      sel_addr  = gnt_port ? addr1  : addr0;
      sel_wdata = gnt_port ? wdata1 : wdata0;
      sel_type  = gnt_port ? type1  : type0;

      sel_mis = 1'b0;
      sel_be  = 4'b0000;
      sel_rep = 32'h0;
      case (sel_type[1:0])
         2'b00: begin
            // Big-endian: byte address 0 of a word lives in bits 31:24.
            sel_be  = 4'b1000 >> sel_addr[1:0];
            sel_rep = {4{sel_wdata[7:0]}};
         end
         2'b01: begin
            sel_mis = sel_addr[0];
            sel_be  = sel_addr[1] ? 4'b0011 : 4'b1100;
            sel_rep = {2{sel_wdata[15:0]}};
         end
         2'b10: begin
            sel_mis = |sel_addr[1:0];
            sel_be  = 4'b1111;
            sel_rep = sel_wdata;
         end
         default: begin
            sel_mis = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      we_d         = we_q;
      type_d       = type_q;
      lane_d       = lane_q;
      mis_d        = mis_q;
      ram_en_d     = 1'b0;
      ram_be_d     = 4'b0000;
      ram_addr_d   = '0;
      ram_wdata_d  = 32'h0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               last_grant_d = gnt_port;
               port_d       = gnt_port;
               we_d         = sel_we;
               type_d       = sel_type;
               lane_d       = sel_addr[1:0];
               mis_d        = sel_mis;
               if (sel_mis) begin
                  // Misaligned: answer straight away, never touch the RAM.
                  state_d = DONE;
                  ack0_d  = ~gnt_port;
                  ack1_d  = gnt_port;
                  err0_d  = ~gnt_port;
                  err1_d  = gnt_port;
               end else begin
                  // RAM command is registered here so it is live in ISSUE.
                  state_d     = ISSUE;
                  ram_en_d    = 1'b1;
                  ram_addr_d  = sel_addr[ADDR_W+1:2];
                  ram_be_d    = sel_we ? sel_be : 4'b0000;
                  ram_wdata_d = sel_rep;
               end
            end
         end
         ISSUE: begin
            state_d = DONE;
            ack0_d  = ~port_q;
            ack1_d  = port_q;
         end
         DONE: begin
            // req is not sampled here; the requester drops it on this edge.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         type_q       <= 3'b000;
         lane_q       <= 2'b00;
         mis_q        <= 1'b0;
         ram_en_q     <= 1'b0;
         ram_be_q     <= 4'b0000;
         ram_addr_q   <= '0;
         ram_wdata_q  <= 32'h0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         we_q         <= we_d;
         type_q       <= type_d;
         lane_q       <= lane_d;
         mis_q        <= mis_d;
         ram_en_q     <= ram_en_d;
         ram_be_q     <= ram_be_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
      end
   end

   // ------------------------------------------------------------------------
   // Load extraction. ram_rdata only becomes valid in DONE, the same cycle as
   // ack, so this path is combinational from it, gated by registered state.
   // ------------------------------------------------------------------------
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] rd_val;

   always_comb begin
      case (lane_q)
         2'b00:   byte_sel = ram_rdata[31:24];
         2'b01:   byte_sel = ram_rdata[23:16];
         2'b10:   byte_sel = ram_rdata[15:8];
         default: byte_sel = ram_rdata[7:0];
      endcase
      half_sel = lane_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];

      case (type_q[1:0])
         2'b00:   load_val = {{24{type_q[2] & byte_sel[7]}}, byte_sel};
         2'b01:   load_val = {{16{type_q[2] & half_sel[15]}}, half_sel};
         default: load_val = ram_rdata;
      endcase

      rd_val = ((state_q == DONE) && !we_q && !mis_q) ? load_val : 32'h0;
   end

   assign rdata0    = port_q ? 32'h0 : rd_val;
   assign rdata1    = port_q ? rd_val : 32'h0;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign err0      = err0_q;
   assign err1      = err1_q;
   assign busy      = (state_q != IDLE);
   assign ram_en    = ram_en_q;
   assign ram_be    = ram_be_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dram_arbiter
//   Drives dram_arbiter against a behavioural word RAM and compares every
//   cycle of every transaction with a byte-addressed big-endian memory model
//   and a transaction-order model (alternating grants on contention).
// ----------------------------------------------------------------------------
module tb_dram_arbiter;

   localparam int ADDR_W = 7;
   localparam int NWORDS = 1 << ADDR_W;
   localparam int NBYTES = 4 * NWORDS;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ty;
   } txn_t;

   logic              clk;
   logic              rst;
   logic              req0, req1, we0, we1;
   logic [31:0]       addr0, addr1, wdata0, wdata1;
   logic [2:0]        type0, type1;
   logic              ack0, ack1, err0, err1;
   logic [31:0]       rdata0, rdata1;
   logic              busy, ram_en;
   logic [3:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_rdata;
   logic [1:0]        unused_dbg_state;

   dram_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .type0(type0), .type1(type1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .ram_en(ram_en), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .dbg_state(unused_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural RAM ----------------
   logic [31:0] ram_mem [NWORDS];

   function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Read data is garbage except the cycle after a RAM cycle.
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata          <= ram_mem[ram_addr];
         ram_mem[ram_addr]  <= merge_word(ram_mem[ram_addr], ram_wdata, ram_be);
      end else begin
         ram_rdata <= $urandom;
      end
   end

   // ---------------- scoreboard / reference model ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   int         last_gnt = 1;
   logic [7:0] ref_bytes [NBYTES];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Applies one access to the byte model and returns what the DUT must show.
   task automatic model_txn(input txn_t t, output logic mis, output logic [3:0] be,
                            output logic [31:0] wd, output logic [31:0] rd,
                            output logic [ADDR_W-1:0] waddr);
      int n, a, lane;
      logic [31:0] v;
      mis = (t.ty[1:0] == 2'b11) || (t.ty[1:0] == 2'b01 && t.addr[0]) ||
            (t.ty[1:0] == 2'b10 && t.addr[1:0] != 2'b00);
      n     = 1 << t.ty[1:0];
      a     = int'(t.addr[ADDR_W+1:0]);
      waddr = t.addr[ADDR_W+1:2];
      be = 4'b0000; wd = 32'h0; rd = 32'h0;
      if (!mis) begin
         for (int l = 0; l < 4; l++) wd[8*l +: 8] = t.wdata[8*(l % n) +: 8];
         if (t.we) begin
            for (int i = 0; i < n; i++) begin
               lane = 3 - ((a + i) % 4);
               be[lane] = 1'b1;
               ref_bytes[(a + i) % NBYTES] = t.wdata[8*(n-1-i) +: 8];
            end
         end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = {v[23:0], ref_bytes[(a + i) % NBYTES]};
            if (t.ty[2] && v[8*n-1])
               for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
            rd = v;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_port(input int p, input logic req, input txn_t t);
      if (p == 0) begin
         req0 = req; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; type0 = t.ty;
      end else begin
         req1 = req; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; type1 = t.ty;
      end
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = $urandom;
      t.wdata = $urandom;
      t.ty    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
         if (t.ty[1:0] == 2'b01) t.addr[0] = 1'b0;
         if (t.ty[1:0] == 2'b10) t.addr[1:0] = 2'b00;
      end
      return t;
   endfunction

   function automatic txn_t mk(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] ty);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata; t.ty = ty;
      return t;
   endfunction

   // Entered at #1 after a rising edge with the DUT idle; that cycle is cycle
   // 0. Requesters drop req on the edge where they see their ack.
   task automatic run_txns(input txn_t t0, input txn_t t1, input logic a0, input logic a1);
      txn_t              tt [2];
      logic              act [2];
      int                st_c [2], ram_c [2], ack_c [2];
      logic              mis_e [2];
      logic [3:0]        be_e [2];
      logic [31:0]       wd_e [2], rd_e [2];
      logic [ADDR_W-1:0] wa_e [2];
      logic              m;
      logic [3:0]        b;
      logic [31:0]       w, r;
      logic [ADDR_W-1:0] wa;
      int                first, nxt, end_c, own;
      logic              exp_en, exp_busy, exp_ack, got_ack;
      logic              drop [2];

      tt[0] = t0; tt[1] = t1; act[0] = a0; act[1] = a1;
      for (int p = 0; p < 2; p++) begin
         st_c[p] = -100; ram_c[p] = -100; ack_c[p] = -100;
         mis_e[p] = 1'b0; be_e[p] = '0; wd_e[p] = '0; rd_e[p] = '0; wa_e[p] = '0;
         drop[p] = 1'b0;
      end
      first = (a0 && a1) ? (1 - last_gnt) : (a1 ? 1 : 0);
      nxt   = 0;
      for (int k = 0; k < 2; k++) begin
         int p;
         p = (k == 0) ? first : 1 - first;
         if (act[p]) begin
            model_txn(tt[p], m, b, w, r, wa);
            mis_e[p] = m; be_e[p] = b; wd_e[p] = w; rd_e[p] = r; wa_e[p] = wa;
            st_c[p]  = nxt;
            ram_c[p] = m ? -100 : nxt + 1;
            ack_c[p] = nxt + (m ? 1 : 2);
            nxt      = ack_c[p] + 1;
            last_gnt = p;
         end
      end
      end_c = nxt - 1;

      drive_port(0, a0, t0);
      drive_port(1, a1, t1);
      for (int cyc = 0; cyc <= end_c; cyc++) begin
         @(negedge clk);
         exp_en = 1'b0; exp_busy = 1'b0; own = 0;
         for (int p = 0; p < 2; p++) begin
            if (act[p] && ram_c[p] == cyc) begin exp_en = 1'b1; own = p; end
            if (act[p] && cyc > st_c[p] && cyc <= ack_c[p]) exp_busy = 1'b1;
         end
         check("ram_en", 32'(ram_en), 32'(exp_en));
         check("busy", 32'(busy), 32'(exp_busy));
         if (exp_en) begin
            check("ram_addr", 32'(ram_addr), 32'(wa_e[own]));
            check("ram_be", 32'(ram_be), 32'(be_e[own]));
            if (tt[own].we) check("ram_wdata", ram_wdata, wd_e[own]);
         end
         for (int p = 0; p < 2; p++) begin
            exp_ack = act[p] && (ack_c[p] == cyc);
            got_ack = (p == 0) ? ack0 : ack1;
            check($sformatf("ack%0d", p), 32'(got_ack), 32'(exp_ack));
            if (exp_ack) begin
               check($sformatf("err%0d", p), 32'((p == 0) ? err0 : err1), 32'(mis_e[p]));
               check($sformatf("rdata%0d", p), (p == 0) ? rdata0 : rdata1, rd_e[p]);
            end
            if (got_ack) drop[p] = 1'b1;
         end
         if (cyc != end_c) begin
            @(posedge clk); #1;
            if (drop[0]) req0 = 1'b0;
            if (drop[1]) req1 = 1'b0;
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack0"}, 32'(ack0), 32'h0);
      check({tag, "_ack1"}, 32'(ack1), 32'h0);
      check({tag, "_err"}, 32'({err0, err1}), 32'h0);
      check({tag, "_rdata0"}, rdata0, 32'h0);
      check({tag, "_rdata1"}, rdata1, 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_ram_en"}, 32'(ram_en), 32'h0);
      check({tag, "_ram_be"}, 32'(ram_be), 32'h0);
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
      check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      last_gnt = 1;
   endtask

   // ---------------- main sequence ----------------
   txn_t nil;

   initial begin
      nil = mk(1'b0, 32'h0, 32'h0, 3'b010);
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; type0 = '0; type1 = '0;
      #2;
      do_reset();

      // Byte store right after reset.
      run_txns(mk(1'b1, 32'h0000_0005, 32'h0000_00A5, 3'b000), nil, 1'b1, 1'b0);

      // Fill the whole RAM with known words through both ports.
      for (int i = 0; i < NWORDS; i++) begin
         if (i % 2 == 0)
            run_txns(mk(1'b1, 32'(4*i), $urandom, 3'b010), nil, 1'b1, 1'b0);
         else
            run_txns(nil, mk(1'b1, 32'(4*i), $urandom, 3'b010), 1'b0, 1'b1);
      end

      // Byte loads with and without sign extension.
      run_txns(mk(1'b1, 32'h0000_0004, 32'h12A5_3456, 3'b010), nil, 1'b1, 1'b0);
      run_txns(mk(1'b0, 32'h0000_0005, $urandom, 3'b100), nil, 1'b1, 1'b0);
      run_txns(mk(1'b0, 32'h0000_0005, $urandom, 3'b000), nil, 1'b1, 1'b0);

      // Halfword loads on port 1.
      run_txns(nil, mk(1'b1, 32'h0000_0004, 32'hDEAD_8001, 3'b010), 1'b0, 1'b1);
      run_txns(nil, mk(1'b0, 32'h0000_0006, $urandom, 3'b001), 1'b0, 1'b1);
      run_txns(nil, mk(1'b0, 32'h0000_0006, $urandom, 3'b101), 1'b0, 1'b1);

      // Misaligned word store and reserved type.
      run_txns(nil, mk(1'b1, 32'h0000_0002, 32'h1234_5678, 3'b010), 1'b0, 1'b1);
      run_txns(mk(1'b0, 32'h0000_0008, 32'h0, 3'b011), nil, 1'b1, 1'b0);

      // Randomized single and contended traffic.
      for (int i = 0; i < 200; i++) begin
         int mode;
         mode = $urandom_range(0, 2);
         run_txns(rand_txn(), rand_txn(), mode != 1, mode != 0);
      end

      // Both ports held continuously after reset: grants alternate.
      do_reset();
      drive_port(0, 1'b1, mk(1'b0, 32'h0000_0000, 32'h0, 3'b010));
      drive_port(1, 1'b1, mk(1'b0, 32'h0000_0004, 32'h0, 3'b010));
      for (int cyc = 0; cyc <= 8; cyc++) begin
         @(negedge clk);
         check("held_ack0", 32'(ack0), 32'(cyc == 2 || cyc == 8));
         check("held_ack1", 32'(ack1), 32'(cyc == 5));
         if (cyc != 8) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      last_gnt = 0;

      // Reset during ISSUE aborts the access; the held request is then served.
      drive_port(0, 1'b1, mk(1'b0, 32'h0000_0008, 32'h0, 3'b010));
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_ram_en", 32'(ram_en), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("abort");
      @(posedge clk); #1;
      check("abort_no_ack", 32'(ack0), 32'h0);
      check("abort_no_ram", 32'(ram_en), 32'h0);
      rst = 1'b1;
      last_gnt = 1;
      run_txns(mk(1'b0, 32'h0000_0008, 32'h0, 3'b010), nil, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
